bin_tree: RTL and testbench

Parameterized, pipelined population-count block: it counts the set bits of an NDATA-bit input vector through a binary adder tree with one register stage per tree level. It sits in the datapath wherever a ones-count of a wide word is needed, for example weight or match counting. It accepts one word per clock, fully pipelined, with a valid flag travelling alongside the data.

---
 rtl/bin_tree_pkg.sv | 24 ++
 rtl/bin_tree_level.sv | 28 ++
 rtl/bin_tree.sv | 63 ++++++
 tb/tb_bin_tree.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bin_tree_pkg.sv
// Shared sizing helpers for the bin_tree population-count adder tree.
package bin_tree_pkg;

    // Bit width of one node at tree level k (level 0 = input bits).
    function automatic int unsigned level_width(input int unsigned k);
        return k + 1;
    endfunction

    // Number of nodes at tree level k for a tree of ndata_log levels.
    function automatic int unsigned level_nodes(input int unsigned ndata_log, input int unsigned k);
        return 32'd1 << (ndata_log - k);
    endfunction

    // Bit offset of level k inside the flattened all-levels tree vector.
    function automatic int unsigned level_offset(input int unsigned ndata_log, input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < k; j++) begin
            off += level_nodes(ndata_log, j) * level_width(j);
        end
        return off;
    endfunction

endpackage

// File: rtl/bin_tree_level.sv
// One registered level of the adder tree: pairwise sums, each widened by one bit.
module bin_tree_level
    import bin_tree_pkg::*;
#(
    parameter int unsigned IN_NODES = 2,
    parameter int unsigned IN_W     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [IN_NODES*IN_W-1:0]              din,
    output logic [(IN_NODES/2)*(IN_W+1)-1:0]      dout
);

    localparam int unsigned OUT_NODES = IN_NODES / 2;
    localparam int unsigned OUT_W     = IN_W + 1;

    for (genvar i = 0; i < OUT_NODES; i++) begin : g_node
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout[i*OUT_W +: OUT_W] <= '0;
            end else begin
                dout[i*OUT_W +: OUT_W] <= OUT_W'(din[(2*i)*IN_W +: IN_W])
                                        + OUT_W'(din[(2*i+1)*IN_W +: IN_W]);
            end
        end
    end

endmodule

// File: rtl/bin_tree.sv
// Pipelined population count: binary adder tree, one register stage per level.
module bin_tree
    import bin_tree_pkg::*;
#(
    parameter int unsigned NDATA = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NDATA-1:0]         din,
    input  logic                     din_valid,
    output logic [$clog2(NDATA):0]   dout,
    output logic                     dout_valid
);

    localparam int unsigned NDATA_LOG = $clog2(NDATA);
    localparam int unsigned NPAD      = level_nodes(NDATA_LOG, 0);
    localparam int unsigned TREE_W    = level_offset(NDATA_LOG, NDATA_LOG + 1);
    localparam int unsigned ROOT_OFF  = level_offset(NDATA_LOG, NDATA_LOG);

    if (NDATA < 2) begin : g_chk
        $error("bin_tree: NDATA must be at least 2");
    end

    // All levels packed back to back; level 0 is the zero-padded input word.
    wire [TREE_W-1:0] tree;

    assign tree[NPAD-1:0] = NPAD'(din);

    for (genvar k = 1; k <= NDATA_LOG; k++) begin : g_lvl
        localparam int unsigned IN_OFF  = level_offset(NDATA_LOG, k - 1);
        localparam int unsigned OUT_OFF = level_offset(NDATA_LOG, k);
        localparam int unsigned IN_N    = level_nodes(NDATA_LOG, k - 1);
        localparam int unsigned IN_W    = level_width(k - 1);
        localparam int unsigned OUT_N   = level_nodes(NDATA_LOG, k);
        localparam int unsigned OUT_W   = level_width(k);

        bin_tree_level #(
            .IN_NODES (IN_N),
            .IN_W     (IN_W)
        ) u_level (
            .clk  (clk),
            .rst  (rst),
            .din  (tree[IN_OFF +: IN_N*IN_W]),
            .dout (tree[OUT_OFF +: OUT_N*OUT_W])
        );
    end

    assign dout = tree[ROOT_OFF +: NDATA_LOG+1];

    // Valid flag travels alongside the tree, one stage per level.
    logic [NDATA_LOG-1:0] vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= NDATA_LOG'({vld, din_valid});
        end
    end

    assign dout_valid = vld[NDATA_LOG-1];

endmodule

// File: tb/tb_bin_tree.sv
// Scoreboard bench for bin_tree (NDATA=128): expected counts queued at drive time.
module tb_bin_tree;

    localparam int unsigned NDATA = 128;
    localparam int unsigned LAT   = 7;

    typedef struct packed {
        logic [31:0] due;
        logic        v;
        logic [7:0]  cnt;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [NDATA-1:0] din;
    logic             din_valid;
    logic [7:0]       dout;
    logic             dout_valid;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_checks;
    int          n_fails;

    bin_tree #(.NDATA(NDATA)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Compare outputs against the scoreboard, or against reset state if nothing is due.
    task automatic check_out();
        exp_t e;
        if (rst || sb.size() == 0 || sb[0].due != cyc) begin
            check("idle_dout", 32'(dout), 32'd0);
            check("idle_valid", 32'(dout_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            check("dout", 32'(dout), 32'(e.cnt));
            check("dout_valid", 32'(dout_valid), 32'(e.v));
        end
    endtask

    task automatic step(input logic [NDATA-1:0] d, input logic v);
        exp_t e;
        din       = d;
        din_valid = v;
        if (!rst) begin
            e.due = cyc + LAT;
            e.v   = v;
            e.cnt = 8'($countones(d));
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        check_out();
    endtask

    function automatic logic [NDATA-1:0] rand_word();
        logic [NDATA-1:0] w;
        for (int j = 0; j < 4; j++) w[j*32 +: 32] = $urandom;
        case ($urandom_range(0, 3))
            0: w = w & {4{$urandom}};
            1: w = w | {4{$urandom}};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [NDATA-1:0] ones;
        logic [NDATA-1:0] one;
        ones      = '1;
        one       = NDATA'(1);
        n_checks  = 0;
        n_fails   = 0;
        cyc       = 0;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;

        // Reset held with all-ones valid input: outputs stay zero.
        for (int i = 0; i < 4; i++) step(ones, 1'b1);
        rst = 1'b0;

        step(ones, 1'b1);
        step({16{8'hF0}}, 1'b1);
        step({16{8'h0F}}, 1'b1);
        step('0, 1'b1);
        for (int i = 0; i < 4; i++) step('0, 1'b0);

        // Single-bit walk, then the two extreme bits together.
        for (int i = 0; i < NDATA; i++) step(one << i, 1'b1);
        step(one | (one << (NDATA - 1)), 1'b1);
        step(ones, 1'b0);

        for (int i = 0; i < 300; i++) step(rand_word(), $urandom_range(0, 3) != 0);

        // Asynchronous reset with three valid words in flight.
        step(ones, 1'b1);
        step({16{8'hA5}}, 1'b1);
        step(one, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_dout", 32'(dout), 32'd0);
        check("rst_async_valid", 32'(dout_valid), 32'd0);
        sb.delete();
        step(ones, 1'b1);
        step(ones, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) step(ones, 1'b0);
        step({16{8'h81}}, 1'b1);
        for (int i = 0; i < LAT + 2; i++) step(rand_word(), 1'b0);

        if (sb.size() > LAT) begin
            n_fails++;
            $display("FAIL scoreboard_drain: %0d entries left, at most %0d allowed", sb.size(), LAT);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
